// File: rtl/ddr_responder.sv
// Simulation-side DDR responder: accepts one single-word or 8-word line request,
// applies a bit-masked write or a read after LATENCY idle cycles, then pulses done.
module ddr_responder #(
  parameter int DEPTH_LOG = 16,
  parameter int LATENCY   = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         ddr_chip_enable,
  input  logic [63:0]  ddr_index,
  input  logic         ddr_write_enable,
  input  logic         ddr_burst_mode,
  input  logic [511:0] ddr_write_mask,
  input  logic [511:0] ddr_write_data,
  output logic [511:0] ddr_read_data,
  output logic         ddr_operation_done,
  output logic         ddr_ready
);

  // state    | meaning
  // ST_IDLE  | ready, waiting for chip_enable
  // ST_WAIT  | access latency countdown
  // ST_XFER  | one beat per cycle, beat_q = k
  // ST_DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_XFER, ST_DONE} state_e;

  localparam logic [7:0] LAT = LATENCY[7:0];

  state_e                 state_q, state_d;
  logic [DEPTH_LOG-1:0]   idx_q, idx_d;
  logic                   we_q, we_d;
  logic                   burst_q, burst_d;
  logic [511:0]           mask_q, mask_d;
  logic [511:0]           wdata_q, wdata_d;
  logic [7:0]             wait_q, wait_d;
  logic [2:0]             beat_q, beat_d;
  logic [511:0]           line_q, line_d;
  logic [511:0]           rdata_q, rdata_d;

  logic [63:0]            mem [0:(2**DEPTH_LOG)-1];
  logic [DEPTH_LOG-1:0]   word_addr;
  logic [8:0]             lane;
  logic [63:0]            mem_rd;
  logic [63:0]            mem_wr_word;
  logic                   mem_wr_en;
  logic                   last_beat;
  logic                   unused_idx_hi;

  // Index bits above the array depth wrap silently.
  assign unused_idx_hi = ^ddr_index[63:DEPTH_LOG];

  assign word_addr   = burst_q ? {idx_q[DEPTH_LOG-1:3], beat_q} : idx_q;
  assign lane        = {beat_q, 6'd0};
  assign mem_rd      = mem[word_addr];
  assign mem_wr_word = (mem_rd & ~mask_q[lane +: 64]) | (wdata_q[lane +: 64] & mask_q[lane +: 64]);
  assign last_beat   = burst_q ? (beat_q == 3'd7) : 1'b1;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    we_d      = we_q;
    burst_d   = burst_q;
    mask_d    = mask_q;
    wdata_d   = wdata_q;
    wait_d    = wait_q;
    beat_d    = beat_q;
    line_d    = line_q;
    rdata_d   = rdata_q;
    mem_wr_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ddr_chip_enable) begin
          idx_d   = ddr_index[DEPTH_LOG-1:0];
          we_d    = ddr_write_enable;
          burst_d = ddr_burst_mode;
          mask_d  = ddr_write_mask;
          wdata_d = ddr_write_data;
          wait_d  = LAT;
          beat_d  = 3'd0;
          line_d  = '0;
          state_d = (LATENCY == 0) ? ST_XFER : ST_WAIT;
        end
      end
      ST_WAIT: begin
        wait_d = wait_q - 8'd1;
        if (wait_q == 8'd1) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (we_q) mem_wr_en = 1'b1;
        else      line_d[lane +: 64] = mem_rd;
        beat_d = beat_q + 3'd1;
        if (last_beat) begin
          state_d = ST_DONE;
          // read_data must already include the final beat on the done cycle
          if (!we_q) rdata_d = line_d;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      we_q    <= 1'b0;
      burst_q <= 1'b0;
      mask_q  <= '0;
      wdata_q <= '0;
      wait_q  <= '0;
      beat_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      burst_q <= burst_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory is deliberately not reset; an async reset stops further beats via state_q.
  always_ff @(posedge clock) begin
    if (mem_wr_en) mem[word_addr] <= mem_wr_word;
  end

  assign ddr_read_data      = rdata_q;
  assign ddr_operation_done = (state_q == ST_DONE);
  assign ddr_ready          = (state_q == ST_IDLE);

endmodule

// File: tb/tb_ddr_responder.sv
// Directed bench for ddr_responder: default instance plus a DEPTH_LOG=4, LATENCY=0 instance.
module tb_ddr_responder;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;

  logic         ce = 1'b0, we = 1'b0, bm = 1'b0;
  logic [63:0]  idx = '0;
  logic [511:0] mask = '0, wdata = '0;
  logic [511:0] rd;
  logic         done, rdy;

  logic         z_ce = 1'b0, z_we = 1'b0, z_bm = 1'b0;
  logic [63:0]  z_idx = '0;
  logic [511:0] z_mask = '0, z_wdata = '0;
  logic [511:0] z_rd;
  logic         z_done, z_rdy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  ddr_responder dut (
    .clock(clock), .reset_n(reset_n), .ddr_chip_enable(ce), .ddr_index(idx),
    .ddr_write_enable(we), .ddr_burst_mode(bm), .ddr_write_mask(mask),
    .ddr_write_data(wdata), .ddr_read_data(rd), .ddr_operation_done(done),
    .ddr_ready(rdy)
  );

  ddr_responder #(.DEPTH_LOG(4), .LATENCY(0)) dut_z (
    .clock(clock), .reset_n(reset_n), .ddr_chip_enable(z_ce), .ddr_index(z_idx),
    .ddr_write_enable(z_we), .ddr_burst_mode(z_bm), .ddr_write_mask(z_mask),
    .ddr_write_data(z_wdata), .ddr_read_data(z_rd), .ddr_operation_done(z_done),
    .ddr_ready(z_rdy)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] ramp(input logic [63:0] base);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[64*k +: 64] = base + 64'(k);
    return r;
  endfunction

  // Issue one request on the default instance; returns the cycle of the done pulse (-1 on timeout).
  task automatic req(input logic [63:0] i, input logic w, input logic b,
                     input logic [511:0] m, input logic [511:0] d, output int dc);
    int g;
    g = 0;
    while (!rdy && g < 50) begin @(negedge clock); g++; end
    if (!rdy) chk("ready_wait", 512'(rdy), 512'(1));
    ce = 1'b1; idx = i; we = w; bm = b; mask = m; wdata = d;
    @(posedge clock);
    #1 ce = 1'b0;
    dc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (done) begin dc = c; break; end
    end
    if (dc < 0) chk("done_wait", 512'(done), 512'(1));
  endtask

  localparam logic [511:0] ONES = {512{1'b1}};

  initial begin
    int dc, nd, d1, d2;
    logic [511:0] exp;

    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, nd, d1, d2;
    logic [511:0] exp;

    repeat (2) @(negedge clock);
    chk("rst_ready", 512'(rdy), 512'(1));
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_rdata", rd, '0);
    chk("rst_z_ready", 512'(z_rdy), 512'(1));
    reset_n = 1'b1;
    @(negedge clock);

    // single write then read
    req(64'h10, 1'b1, 1'b0, ONES, {448'b0, 64'hDEADBEEF_CAFEF00D}, dc);
    chk("wr_lat", 512'(dc), 512'(6));
    req(64'h10, 1'b0, 1'b0, '0, '0, dc);
    chk("rd_lat", 512'(dc), 512'(6));
    chk("rd_data", rd, {448'b0, 64'hDEADBEEF_CAFEF00D});

    // masked partial write
    req(64'h20, 1'b1, 1'b0, ONES, {448'b0, 64'hFFFF_FFFF_FFFF_FFFF}, dc);
    req(64'h20, 1'b1, 1'b0, {448'b0, 64'h0000_0000_FFFF_0000}, '0, dc);
    chk("mask_wr_rd_hold", rd, {448'b0, 64'hDEADBEEF_CAFEF00D});
    req(64'h20, 1'b0, 1'b0, '0, '0, dc);
    chk("mask_data", rd, {448'b0, 64'hFFFF_FFFF_0000_FFFF});

    // burst alignment
    req(64'h43, 1'b1, 1'b1, ONES, ramp(64'd1), dc);
    chk("bwr_lat", 512'(dc), 512'(13));
    req(64'h47, 1'b0, 1'b1, '0, '0, dc);
    chk("brd_lat", 512'(dc), 512'(13));
    chk("brd_data", rd, ramp(64'd1));
    req(64'h40, 1'b0, 1'b0, '0, '0, dc);
    chk("bword40", rd, {448'b0, 64'd1});
    req(64'h47, 1'b0, 1'b0, '0, '0, dc);
    chk("bword47", rd, {448'b0, 64'd8});

    // request while busy
    while (!rdy) @(negedge clock);
    ce = 1'b1; idx = 64'h10; we = 1'b0; bm = 1'b0;
    @(posedge clock);
    #1 ce = 1'b0;
    nd = 0; d1 = -1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      chk($sformatf("busy_rdy_c%0d", c), 512'(rdy), 512'(c == 7));
      if (done) begin nd++; d1 = c; end
      if (c == 2 || c == 5) begin
        ce = 1'b1; idx = 64'h10; we = 1'b1; bm = 1'b0; mask = ONES; wdata = '0;
      end else begin
        ce = 1'b0;
      end
    end
    chk("busy_ndone", 512'(nd), 512'(1));
    chk("busy_lat", 512'(d1), 512'(6));
    chk("busy_rdata", rd, {448'b0, 64'hDEADBEEF_CAFEF00D});
    req(64'h10, 1'b0, 1'b0, '0, '0, dc);
    chk("busy_mem", rd, {448'b0, 64'hDEADBEEF_CAFEF00D});

    // reset mid-burst
    req(64'h80, 1'b1, 1'b1, ONES, ramp(64'h100), dc);
    while (!rdy) @(negedge clock);
    ce = 1'b1; idx = 64'h80; we = 1'b1; bm = 1'b1; mask = ONES; wdata = ramp(64'hA0);
    @(posedge clock);
    #1 ce = 1'b0;
    nd = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (done) nd++;
    end
    reset_n = 1'b0;
    #1;
    chk("abort_ready", 512'(rdy), 512'(1));
    chk("abort_rdata", rd, '0);
    chk("abort_done", 512'(done), 512'(0));
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (done) nd++;
    end
    chk("abort_ndone", 512'(nd), 512'(0));
    exp = ramp(64'h100);
    exp[0 +: 64] = 64'hA0;
    exp[64 +: 64] = 64'hA1;
    exp[128 +: 64] = 64'hA2;
    req(64'h80, 1'b0, 1'b1, '0, '0, dc);
    chk("abort_mem", rd, exp);

    // LATENCY=0, DEPTH_LOG=4: wrap and back-to-back
    @(negedge clock);
    z_ce = 1'b1; z_we = 1'b1; z_bm = 1'b0; z_idx = 64'h13;
    z_mask = ONES; z_wdata = {448'b0, 64'h1234};
    @(posedge clock);
    #1 z_we = 1'b0; z_idx = 64'h3; z_wdata = '0;
    nd = 0; d1 = -1; d2 = -1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      if (c == 3) chk("z_rdy_c3", 512'(z_rdy), 512'(1));
      if (z_done) begin
        nd++;
        if (nd == 1) d1 = c;
        else d2 = c;
      end
      if (c == 4) z_ce = 1'b0;
    end
    chk("z_ndone", 512'(nd), 512'(2));
    chk("z_wr_lat", 512'(d1), 512'(2));
    chk("z_rd_lat", 512'(d2), 512'(5));
    chk("z_wrap_data", z_rd, {448'b0, 64'h1234});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_responder.md
# ddr_responder

Simulation-side DDR responder that terminates the DDR request port driven by the core's channel arbiter. It accepts one single-word or cache-line burst request at a time and applies a bit-masked write to, or a read from, an internal 64-bit-word memory array. After a programmable access latency it returns a one-cycle completion pulse. It sits in the testbench/SoC wrapper directly opposite the core's `ddr_*` ports.

## Interface
- `DEPTH_LOG`, 16: log2 of memory depth in 64-bit words; array is 2^DEPTH_LOG words.
- `LATENCY`, 4: idle cycles between accept and first transfer beat; legal range 0–255.
- `clock` input 1: single clock; all state updates on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `ddr_chip_enable` input 1: request strobe; sampled only while `ddr_ready`=1.
- `ddr_index` input 64: 64-bit word index; only bits [DEPTH_LOG-1:0] are used.
- `ddr_write_enable` input 1: 1 = write, 0 = read.
- `ddr_burst_mode` input 1: 1 = 8-word line access, 0 = single word.
- `ddr_write_mask` input 512: per-bit write mask; a set bit updates that bit.
- `ddr_write_data` input 512: write data.
- `ddr_read_data` output 512: read result; valid from the `ddr_operation_done` cycle onward.
- `ddr_operation_done` output 1: one-cycle completion pulse.
- `ddr_ready` output 1: responder idle and able to accept a request.

## Operation
- FSM states: IDLE, WAIT, XFER, DONE. `ddr_ready` = (state==IDLE). Reset state is IDLE.
- **Accept:** on a rising edge with state IDLE and `ddr_chip_enable`=1, the responder latches index, write_enable, burst_mode, mask and data into request registers.
  - Later changes on the inputs have no effect on the request in flight.
  - `ddr_chip_enable` in any non-IDLE state is ignored. Requests are not queued.
- **Address:** word address a = index[DEPTH_LOG-1:0].
  - Burst: base = {a[DEPTH_LOG-1:3], 3'b000}, so index[2:0] is ignored and words base+0..base+7 are accessed.
  - Single: word a only.
  - Index bits above DEPTH_LOG wrap silently, i.e. modulo depth.
- **Beat count:** N = 8 for burst, 1 for single.
- **WAIT:** a down-counter is loaded with LATENCY. If LATENCY=0, the FSM goes straight from IDLE to XFER.
- **XFER:** one beat per cycle, beat k = 0..N-1.
  - Burst write: mem[base+k] = (mem & ~mask[64k+63:64k]) | (data[64k+63:64k] & mask[64k+63:64k]).
  - Burst read: line_reg[64k+63:64k] = mem[base+k].
  - Single: same as burst with k=0 at word a. On a read, line_reg[511:64] is cleared to 0.
- **DONE:** `ddr_operation_done`=1 for exactly one cycle, then the FSM returns to IDLE.
- **Read data:**
  - `ddr_read_data` is loaded from line_reg on entry to DONE for reads only.
  - It holds its value until the next read's DONE.
  - Writes leave it unchanged.
- A read following a write to the same word always returns the updated value. Beats commit in order.
- Memory contents are not reset. Reads of words never written return X in simulation.
- **Reset mid-operation:** the FSM returns to IDLE and the request is discarded. Beats already committed stay in memory; remaining beats are never written. No done pulse is issued for the aborted request.

## Timing
- Let cycle 0 be the cycle whose closing edge performs the accept.
- Cycles 1..LATENCY: WAIT.
- Cycles LATENCY+1..LATENCY+N: XFER.
- Cycle LATENCY+N+1: DONE (`ddr_operation_done`=1, `ddr_ready`=0).
- Cycle LATENCY+N+2: IDLE, `ddr_ready`=1.
- Accept-to-done latency is LATENCY+N+1 cycles:
  - defaults, single: done in cycle 6;
  - defaults, burst: done in cycle 13;
  - LATENCY=0, single: done in cycle 2.
- Back-to-back: if `ddr_chip_enable` is held high, the next accept occurs in the IDLE cycle after DONE. Requests therefore complete at most once every LATENCY+N+2 cycles.
- Reset values: `ddr_ready`=1, `ddr_operation_done`=0, `ddr_read_data`=0. The WAIT counter, beat counter and request registers are all cleared to 0.

## Test plan
- **Single write then read:** write index 0x10, data[63:0]=0xDEADBEEF_CAFEF00D, mask[63:0]=all ones. Then read 0x10 -> done in cycle 6 of each request; read_data = {448'b0, 0xDEADBEEF_CAFEF00D}.
- **Masked partial write:** word 0x20 preset to 0xFFFF_FFFF_FFFF_FFFF; write data 0, mask[63:0]=0x0000_0000_FFFF_0000 -> a subsequent read returns 0xFFFF_FFFF_0000_FFFF.
- **Burst alignment:** burst write at index 0x43 with data word k = k+1 and full mask; burst read at 0x47 -> read_data word k = k+1 for k=0..7, with words at 0x40..0x47. Done asserted in cycle 13 for both requests.
- **Request while busy:** accept a read; pulse `ddr_chip_enable` with a write in cycles 2 and 5 -> write ignored, memory unchanged, exactly one done pulse. `ddr_ready` is 0 from cycle 1 through cycle 6 and 1 in cycle 7.
- **Reset mid-burst:** burst write to 0x80 with full mask, data word k = 0xA0+k; assert `reset_n`=0 in XFER beat 3 (cycle 8) -> words 0x80..0x82 updated, 0x83..0x87 keep their old values. No done pulse; `ddr_ready`=1 and `ddr_read_data`=0 immediately on reset assertion.
- **LATENCY=0 and wrap:** with DEPTH_LOG=4, single write to index 0x13 -> lands at word 3 (0x13 mod 16); done in cycle 2. Back-to-back read with chip_enable held high -> accepted in cycle 3, done in cycle 5.
